// File: rtl/vblank_dma_pkg.sv
// Shared definitions for the vblank DMA block: register offsets, CTRL/STATUS bits,
// destination RAM selects and the transfer FSM state encoding.
package vblank_dma_pkg;

    localparam logic [1:0] REG_SRC_PAGE = 2'd0;
    localparam logic [1:0] REG_DST      = 2'd1;
    localparam logic [1:0] REG_LEN      = 2'd2;
    localparam logic [1:0] REG_CTRL     = 2'd3;

    localparam int CTRL_ARM   = 0;
    localparam int CTRL_ABORT = 1;

    localparam int STAT_ARMED = 0;
    localparam int STAT_BUSY  = 1;
    localparam int STAT_DONE  = 2;

    localparam logic [1:0] DST_CHRAM     = 2'd0;
    localparam logic [1:0] DST_FGCOLRAM  = 2'd1;
    localparam logic [1:0] DST_BGCOLRAM  = 2'd2;
    localparam logic [1:0] DST_SPRITERAM = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_XFER  = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

endpackage

// File: rtl/vblank_dma_regs.sv
// CPU-visible register file, read mux and DONE flag for vblank_dma.
// Optional transfer-complete interrupt is built only with VBLANK_DMA_IRQ_EN defined.
module vblank_dma_regs
    import vblank_dma_pkg::*;
(
    input  logic       clk_24,
    input  logic       reset_n,
    input  logic       reg_cs,
    input  logic       reg_wr,
    input  logic [1:0] reg_addr,
    input  logic [7:0] reg_din,
    output logic [7:0] reg_dout,
    input  logic       set_done,
    input  logic       armed,
    input  logic       busy,
    output logic       arm_wr,
    output logic       abort_wr,
    output logic [5:0] src_page,
    output logic [1:0] dst_sel,
    output logic [2:0] dst_page,
    output logic [7:0] len,
    output logic       irq_n
);

    logic wr_en;
    logic ctrl_wr;
    logic done;

    assign wr_en    = reg_cs & reg_wr;
    assign ctrl_wr  = wr_en & (reg_addr == REG_CTRL);
    assign arm_wr   = ctrl_wr & reg_din[CTRL_ARM];
    assign abort_wr = ctrl_wr & reg_din[CTRL_ABORT];

    always_ff @(posedge clk_24 or negedge reset_n) begin
        if (!reset_n) begin
            src_page <= '0;
            dst_sel  <= '0;
            dst_page <= '0;
            len      <= '0;
        end else if (wr_en) begin
            case (reg_addr)
                REG_SRC_PAGE: src_page <= reg_din[5:0];
                REG_DST: begin
                    dst_sel  <= reg_din[5:4];
                    dst_page <= reg_din[2:0];
                end
                REG_LEN: len <= reg_din;
                default: ;
            endcase
        end
    end

    // Completion wins over a coincident CTRL write so a finished transfer is never lost.
    always_ff @(posedge clk_24 or negedge reset_n) begin
        if (!reset_n)
            done <= 1'b0;
        else if (set_done)
            done <= 1'b1;
        else if (ctrl_wr)
            done <= 1'b0;
    end

    always_comb begin
        reg_dout = '0;
        case (reg_addr)
            REG_SRC_PAGE: reg_dout[5:0] = src_page;
            REG_DST: begin
                reg_dout[5:4] = dst_sel;
                reg_dout[2:0] = dst_page;
            end
            REG_LEN: reg_dout = len;
            default: begin
                reg_dout[STAT_DONE]  = done;
                reg_dout[STAT_BUSY]  = busy;
                reg_dout[STAT_ARMED] = armed;
            end
        endcase
    end

`ifdef VBLANK_DMA_IRQ_EN
    logic ctrl_acc;
    logic irq;

    // Any CPU touch of CTRL/STATUS (read or write) acknowledges the interrupt.
    assign ctrl_acc = reg_cs & (reg_addr == REG_CTRL);
    assign irq_n    = ~irq;

    always_ff @(posedge clk_24 or negedge reset_n) begin
        if (!reset_n)
            irq <= 1'b0;
        else if (set_done)
            irq <= 1'b1;
        else if (ctrl_acc)
            irq <= 1'b0;
    end
`else
    assign irq_n = 1'b1;
`endif

endmodule

// File: rtl/vblank_dma.sv
// Vertical-blank DMA: copies 1..256 bytes from a work RAM page into a char/colour/sprite
// RAM page once armed and a vblank rising edge arrives. IRQ option: VBLANK_DMA_IRQ_EN.
module vblank_dma
    import vblank_dma_pkg::*;
#(
    parameter int SRC_AW = 14,
    parameter int DST_AW = 11
) (
    input  logic              clk_24,
    input  logic              reset_n,
    input  logic              vblank,
    input  logic              reg_cs,
    input  logic              reg_wr,
    input  logic [1:0]        reg_addr,
    input  logic [7:0]        reg_din,
    output logic [7:0]        reg_dout,
    input  logic              cpu_wkram_req,
    output logic              cpu_wait_n,
    output logic [SRC_AW-1:0] src_addr,
    output logic              src_rd,
    input  logic [7:0]        src_data,
    output logic [DST_AW-1:0] dst_addr,
    output logic [1:0]        dst_sel,
    output logic              dst_wr,
    output logic [7:0]        dst_data,
    output logic              irq_n
);

    state_t     state, state_nxt;
    logic       vblank_q;
    logic       vblank_rise;
    logic       arm_wr, abort_wr;
    logic       load, set_done, xfer, busy;
    logic [7:0] idx;
    logic [5:0] src_page, src_page_l;
    logic [1:0] dst_sel_r;
    logic [2:0] dst_page, dst_page_l;
    logic [7:0] len, len_l;

    vblank_dma_regs u_regs (
        .clk_24   (clk_24),
        .reset_n  (reset_n),
        .reg_cs   (reg_cs),
        .reg_wr   (reg_wr),
        .reg_addr (reg_addr),
        .reg_din  (reg_din),
        .reg_dout (reg_dout),
        .set_done (set_done),
        .armed    (state == ST_ARMED),
        .busy     (busy),
        .arm_wr   (arm_wr),
        .abort_wr (abort_wr),
        .src_page (src_page),
        .dst_sel  (dst_sel_r),
        .dst_page (dst_page),
        .len      (len),
        .irq_n    (irq_n)
    );

    assign xfer        = (state == ST_XFER);
    assign busy        = xfer | (state == ST_FLUSH);
    assign vblank_rise = vblank & ~vblank_q;
    assign load        = (state == ST_ARMED) & vblank_rise & ~abort_wr;
    assign set_done    = (state == ST_FLUSH) & ~abort_wr;

    // An abort in the same cycle suppresses the read so no orphan write follows it.
    assign src_rd     = xfer & ~abort_wr;
    assign src_addr   = src_rd ? SRC_AW'({src_page_l, idx}) : '0;
    assign dst_data   = dst_wr ? src_data : '0;
    assign cpu_wait_n = ~(busy & cpu_wkram_req);

    always_ff @(posedge clk_24 or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            vblank_q <= 1'b0;
        end else begin
            state    <= state_nxt;
            vblank_q <= vblank;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (arm_wr && !abort_wr) state_nxt = ST_ARMED;
            ST_ARMED: if (abort_wr) state_nxt = ST_IDLE;
                      else if (vblank_rise) state_nxt = ST_XFER;
            ST_XFER:  if (abort_wr) state_nxt = ST_IDLE;
                      else if (idx == len_l) state_nxt = ST_FLUSH;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Register values are snapshotted at XFER entry; idx is 8 bits so it wraps inside the page.
    always_ff @(posedge clk_24 or negedge reset_n) begin
        if (!reset_n) begin
            idx        <= '0;
            src_page_l <= '0;
            dst_page_l <= '0;
            len_l      <= '0;
            dst_sel    <= '0;
            dst_wr     <= 1'b0;
            dst_addr   <= '0;
        end else begin
            dst_wr <= src_rd;
            if (src_rd)
                dst_addr <= DST_AW'({dst_page_l, idx});
            if (load) begin
                idx        <= '0;
                src_page_l <= src_page;
                dst_page_l <= dst_page;
                len_l      <= len;
                dst_sel    <= dst_sel_r;
            end else if (xfer) begin
                idx <= idx + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_vblank_dma.sv
// Scoreboard bench for vblank_dma: expected destination writes are queued at setup and
// popped by a monitor whenever dst_wr is seen; directed checks cover status, timing and reset.
`timescale 1ns/1ps
module tb_vblank_dma;

    localparam int SRC_AW = 14;
    localparam int DST_AW = 11;

    logic              clk_24   = 1'b0;
    logic              reset_n  = 1'b1;
    logic              vblank   = 1'b0;
    logic              reg_cs   = 1'b0;
    logic              reg_wr   = 1'b0;
    logic [1:0]        reg_addr = 2'd0;
    logic [7:0]        reg_din  = 8'd0;
    logic              cpu_wkram_req = 1'b0;
    logic [7:0]        reg_dout;
    logic              cpu_wait_n;
    logic [SRC_AW-1:0] src_addr;
    logic              src_rd;
    logic [7:0]        src_data;
    logic [DST_AW-1:0] dst_addr;
    logic [1:0]        dst_sel;
    logic              dst_wr;
    logic [7:0]        dst_data;
    logic              irq_n;

    int passed = 0;
    int total  = 0;
    int wr_count = 0;
    logic [20:0] exp_q[$];

    always #5 clk_24 = ~clk_24;

    vblank_dma #(.SRC_AW(SRC_AW), .DST_AW(DST_AW)) dut (
        .clk_24        (clk_24),
        .reset_n       (reset_n),
        .vblank        (vblank),
        .reg_cs        (reg_cs),
        .reg_wr        (reg_wr),
        .reg_addr      (reg_addr),
        .reg_din       (reg_din),
        .reg_dout      (reg_dout),
        .cpu_wkram_req (cpu_wkram_req),
        .cpu_wait_n    (cpu_wait_n),
        .src_addr      (src_addr),
        .src_rd        (src_rd),
        .src_data      (src_data),
        .dst_addr      (dst_addr),
        .dst_sel       (dst_sel),
        .dst_wr        (dst_wr),
        .dst_data      (dst_data),
        .irq_n         (irq_n)
    );

    function automatic logic [7:0] wram(input logic [13:0] a);
        return (a[7:0] * 8'd7) + ({2'b00, a[13:8]} * 8'd31);
    endfunction

    always @(posedge clk_24) src_data <= wram(src_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    task automatic reg_write(input logic [1:0] a, input logic [7:0] d);
        @(posedge clk_24); #1;
        reg_cs = 1'b1; reg_wr = 1'b1; reg_addr = a; reg_din = d;
        @(posedge clk_24); #1;
        reg_cs = 1'b0; reg_wr = 1'b0;
    endtask

    task automatic reg_read(input logic [1:0] a, output logic [7:0] d);
        @(posedge clk_24); #1;
        reg_cs = 1'b1; reg_wr = 1'b0; reg_addr = a;
        #2 d = reg_dout;
        @(posedge clk_24); #1;
        reg_cs = 1'b0;
    endtask

    task automatic setup(input logic [5:0] sp, input logic [1:0] sel, input logic [2:0] pg,
                         input logic [7:0] len);
        reg_write(2'd0, {2'b00, sp});
        reg_write(2'd1, {2'b00, sel, 1'b0, pg});
        reg_write(2'd2, len);
        for (int i = 0; i <= int'(len); i++)
            exp_q.push_back({sel, pg, 8'(i), wram({sp, 8'(i)})});
    endtask

    task automatic wait_src_rd(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk_24);
            if (src_rd === 1'b1) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_done(input int bound, output bit ok);
        ok = 1'b0;
        reg_addr = 2'd3;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk_24);
            if (reg_dout[2] === 1'b1) begin ok = 1'b1; break; end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [7:0] d;
        bit ok;
        int n0, cnt;

        fork
            forever begin
                @(negedge clk_24);
                if (dst_wr === 1'b1) begin
                    wr_count++;
                    if (exp_q.size() == 0) begin
                        total++;
                        $display("FAIL unexpected_write: got sel=%0d addr=0x%0h data=0x%0h, want no write",
                                 dst_sel, dst_addr, dst_data);
                    end else begin
                        check("dst_write", {11'b0, dst_sel, dst_addr, dst_data}, {11'b0, exp_q.pop_front()});
                    end
                end
            end
        join_none

        // Reset state, asynchronous assertion
        #1 reset_n = 1'b0;
        #2;
        check("rst_ctl", {src_rd, dst_wr, cpu_wait_n, irq_n}, 4'b0011);
        check("rst_addr", {src_addr, dst_addr}, 0);
        check("rst_sel_data", {dst_sel, dst_data}, 0);
        for (int a = 0; a < 4; a++) begin
            reg_addr = 2'(a); #1;
            check("rst_reg", reg_dout, 0);
        end
        repeat (2) @(posedge clk_24);
        #1 reset_n = 1'b1;

        // Register readback with unused bits
        reg_write(2'd0, 8'hFF);
        reg_write(2'd1, 8'hFF);
        reg_write(2'd2, 8'hA5);
        reg_read(2'd0, d); check("rb_src_page", d, 8'h3F);
        reg_read(2'd1, d); check("rb_dst", d, 8'h37);
        reg_read(2'd2, d); check("rb_len", d, 8'hA5);
        reg_read(2'd3, d); check("rb_status_idle", d, 8'h00);

        // Test 1: 128 bytes to spriteram, DONE timing, CPU wait, IRQ
        setup(6'h03, 2'd3, 3'd0, 8'h7F);
        cpu_wkram_req = 1'b1;
        reg_write(2'd3, 8'h01);
        reg_addr = 2'd3; #1;
        check("t1_armed_status", reg_dout, 8'h01);
        check("t1_wait_armed", cpu_wait_n, 1);
        @(posedge clk_24); #1 vblank = 1'b1;
        wait_src_rd(5, ok);
        check("t1_xfer_start", ok, 1);
        check("t1_wait_xfer", cpu_wait_n, 0);
        check("t1_busy_status", reg_dout, 8'h02);
        repeat (128) @(negedge clk_24);
        check("t1_flush_status", reg_dout, 8'h02);
        check("t1_wait_flush", cpu_wait_n, 0);
        @(negedge clk_24);
        check("t1_done_at_129", reg_dout, 8'h04);
        check("t1_wait_after", cpu_wait_n, 1);
`ifdef VBLANK_DMA_IRQ_EN
        check("t1_irq_low", irq_n, 0);
`else
        check("t1_irq_const", irq_n, 1);
`endif
        check("t1_sb_empty", exp_q.size(), 0);
        vblank = 1'b0;
        cpu_wkram_req = 1'b0;
        reg_read(2'd3, d);
        check("t1_status_read", d, 8'h04);
        check("t1_irq_after_read", irq_n, 1);

        // Test 2: full page, top destination page, reg write and vblank fall mid-transfer
        setup(6'h2A, 2'd1, 3'd7, 8'hFF);
        reg_write(2'd3, 8'h01);
        @(posedge clk_24); #1 vblank = 1'b1;
        wait_src_rd(5, ok);
        check("t2_xfer_start", ok, 1);
        n0 = wr_count;
        reg_write(2'd0, 8'h11);
        vblank = 1'b0;
        wait_done(300, ok);
        check("t2_done", ok, 1);
        check("t2_write_count", wr_count - n0, 256);
        check("t2_sb_empty", exp_q.size(), 0);
        reg_read(2'd0, d);
        check("t2_reg_updated", d, 8'h11);

        // Test 3: arming while vblank already high waits for the next rising edge
        setup(6'h05, 2'd0, 3'd2, 8'h0F);
        @(posedge clk_24); #1 vblank = 1'b1;
        repeat (3) @(posedge clk_24);
        reg_write(2'd3, 8'h01);
        cnt = 0;
        repeat (10) begin
            @(negedge clk_24);
            if (src_rd === 1'b1) cnt++;
        end
        check("t3_no_rd_while_high", cnt, 0);
        reg_addr = 2'd3; #1;
        check("t3_still_armed", reg_dout, 8'h01);
        @(posedge clk_24); #1 vblank = 1'b0;
        repeat (2) @(posedge clk_24);
        #1 vblank = 1'b1;
        wait_src_rd(5, ok);
        check("t3_xfer_start", ok, 1);
        wait_done(50, ok);
        check("t3_done", ok, 1);
        check("t3_sb_empty", exp_q.size(), 0);
        vblank = 1'b0;

        // Test 4: abort after 10 writes
        setup(6'h10, 2'd2, 3'd1, 8'h3F);
        reg_write(2'd3, 8'h01);
        @(posedge clk_24); #1 vblank = 1'b1;
        wait_src_rd(5, ok);
        check("t4_xfer_start", ok, 1);
        n0 = wr_count;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_24);
            if (wr_count >= n0 + 10) begin ok = 1'b1; break; end
        end
        check("t4_reached_10", ok, 1);
        reg_write(2'd3, 8'h02);
        exp_q.delete();
        vblank = 1'b0;
        n0 = wr_count;
        cnt = 0;
        repeat (20) begin
            @(negedge clk_24);
            if (src_rd === 1'b1) cnt++;
        end
        check("t4_no_rd_after_abort", cnt, 0);
        check("t4_no_wr_after_abort", wr_count - n0, 0);
        reg_addr = 2'd3; #1;
        check("t4_status_zero", reg_dout, 8'h00);

        // Test 5: reset mid-transfer
        setup(6'h01, 2'd3, 3'd3, 8'hFF);
        cpu_wkram_req = 1'b1;
        reg_write(2'd3, 8'h01);
        @(posedge clk_24); #1 vblank = 1'b1;
        wait_src_rd(5, ok);
        check("t5_xfer_start", ok, 1);
        repeat (20) @(negedge clk_24);
        check("t5_wait_before_rst", cpu_wait_n, 0);
        #2 reset_n = 1'b0;
        exp_q.delete();
        #1;
        check("t5_rst_ctl", {src_rd, dst_wr, cpu_wait_n, irq_n}, 4'b0011);
        check("t5_rst_addr", {src_addr, dst_addr}, 0);
        check("t5_rst_sel_data", {dst_sel, dst_data}, 0);
        n0 = wr_count;
        repeat (2) @(posedge clk_24);
        #1 reset_n = 1'b1;
        vblank = 1'b0;
        cpu_wkram_req = 1'b0;
        for (int a = 0; a < 4; a++) begin
            reg_read(2'(a), d);
            check("t5_reg_after_rst", d, 0);
        end
        check("t5_no_wr_after_rst", wr_count - n0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/vblank_dma.md
VBLANK_DMA -- requirements
Module: vblank_dma

Interface
REQ-001 SHALL have parameter SRC_AW, default 14, the work RAM address width.
REQ-002 SHALL have parameter DST_AW, default 11, the destination RAM address width (char, colour and sprite RAMs).
REQ-003 SHALL have port clk_24, input, 1 bit: the single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: the reset, which is asynchronous and active-low.
REQ-005 SHALL have port vblank, input, 1 bit: vertical blank, active-high.
REQ-006 SHALL have register-port inputs reg_cs (1), reg_wr (1), reg_addr (2) and reg_din (8): the CPU register access.
REQ-007 SHALL have port reg_dout, output, 8 bits: register read data, combinational.
REQ-008 SHALL have port cpu_wkram_req, input, 1 bit: the CPU is addressing work RAM.
REQ-009 SHALL have port cpu_wait_n, output, 1 bit: the CPU stall.
REQ-010 SHALL have ports src_addr (output, SRC_AW), src_rd (output, 1) and src_data (input, 8): the work RAM read port, with 1-cycle read latency.
REQ-011 SHALL have ports dst_addr (output, DST_AW), dst_sel (output, 2), dst_wr (output, 1) and dst_data (output, 8): the destination write port. dst_sel values: 0 = chram, 1 = fgcolram, 2 = bgcolram, 3 = spriteram.
REQ-012 SHALL have port irq_n, output, 1 bit: transfer-complete interrupt, active-low.

Function
REQ-013 SHALL implement the register map: 0 = SRC_PAGE[5:0]; 1 = {DST_SEL[5:4], DST_PAGE[2:0]}; 2 = LEN, where byte count N = LEN+1 (1..256); 3 = CTRL/STATUS.
REQ-014 SHALL decode CTRL writes as: bit0 = arm, bit1 = abort. Any write to register 3 SHALL clear DONE.
REQ-015 SHALL read STATUS as {5'b0, DONE, BUSY, ARMED}. Registers 0-2 SHALL read back as written, with unused bits reading 0.
REQ-016 SHALL implement the FSM states IDLE, ARMED, XFER and FLUSH.
REQ-017 SHALL transition IDLE->ARMED on an arm write.
REQ-018 SHALL transition ARMED->XFER on a vblank rising edge, detected as a registered 0->1. Arming while vblank is already high SHALL wait for the next rising edge.
REQ-019 In XFER, SHALL assert src_rd with src_addr = {SRC_PAGE, idx[7:0]} each cycle, where idx runs 0..N-1.
REQ-020 SHALL transition XFER->FLUSH after issuing idx = N-1.
REQ-021 SHALL assert dst_wr exactly one cycle after each src_rd, with dst_data = src_data and dst_addr = {DST_PAGE, idx_delayed[7:0]}.
REQ-022 SHALL transition FLUSH->IDLE after the last write, and set DONE in that cycle.
REQ-023 SHALL complete a transfer in N+1 cycles from XFER entry, issuing exactly N writes.
REQ-024 SHALL keep addresses inside the selected page: idx SHALL NOT carry into the page bits.
REQ-025 SHALL latch the register values at XFER entry. Register writes during XFER/FLUSH SHALL update the registers but SHALL NOT affect the running transfer.
REQ-026 SHALL ignore an arm write while in ARMED, XFER or FLUSH.
REQ-027 On an abort write, SHALL go to IDLE on the next cycle from any state, with no further src_rd or dst_wr and DONE left 0. An abort in the same cycle as arm SHALL take precedence.
REQ-028 SHALL NOT stop a transfer when vblank falls during XFER: the transfer runs to completion.
REQ-029 SHALL drive cpu_wait_n = 0 while in XFER or FLUSH and cpu_wkram_req = 1, and 1 otherwise.
REQ-030 SHALL drive BUSY = 1 in XFER and FLUSH; ARMED = 1 in the ARMED state.

Reset
REQ-031 On reset_n low, SHALL asynchronously force state IDLE, all registers 0, DONE=0, src_rd=0, dst_wr=0, src_addr=0, dst_addr=0, dst_sel=0, dst_data=0, cpu_wait_n=1 and irq_n=1.
REQ-032 On reset mid-transfer, SHALL abandon the transfer immediately with no write completing after the reset edge.

Configuration
REQ-033 With VBLANK_DMA_IRQ_EN defined, irq_n SHALL go low in the cycle DONE sets, and stay low until a register 3 read or write, or reset.
REQ-034 Without VBLANK_DMA_IRQ_EN, irq_n SHALL be constant 1 and no IRQ logic SHALL be synthesised.

Structure
REQ-035 SHALL place the register offsets, CTRL/STATUS bit positions, DST_SEL encodings and the FSM state enum in package vblank_dma_pkg.
REQ-036 SHALL contain one sub-module, vblank_dma_regs: the register file, read mux and DONE/IRQ flags. The FSM and datapath SHALL stay in the top.

Verification
REQ-037 SHALL test: SRC_PAGE=0x03, DST_SEL=3, DST_PAGE=0, LEN=0x7F, arm, vblank pulse -> 128 writes to spriteram 0x000..0x07F matching work RAM 0x0300..0x037F; DONE=1 exactly 129 cycles after XFER entry.
REQ-038 SHALL test: LEN=0xFF, DST_PAGE=7 -> 256 writes, dst_addr 0x700..0x7FF, no write to 0x000.
REQ-039 SHALL test: arm while vblank=1 -> no src_rd until vblank 1->0->1; then normal transfer.
REQ-040 SHALL test: abort after 10 writes -> no dst_wr afterwards, DONE=0, STATUS=0x00.
REQ-041 SHALL test: cpu_wkram_req=1 during XFER -> cpu_wait_n=0; after FLUSH -> cpu_wait_n=1. With VBLANK_DMA_IRQ_EN, irq_n low after completion and high after a STATUS read.
REQ-042 SHALL test: reset_n low mid-XFER -> outputs at reset values asynchronously; registers read 0 after release.
